alu_nzcv: RTL and testbench
===========================

ALU_NZCV -- requirements
Module: alu_nzcv

Parameters
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits (legal range N >= 2).

Interface
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, the reset; asynchronous and active-high.
REQ-004 The block SHALL have input i_a, N bits, operand A.
REQ-005 The block SHALL have input i_b, N bits, operand B.
REQ-006 The block SHALL have input i_op, 2 bits, the operation select.
REQ-007 The block SHALL have output o_out, N bits, the combinational result.
REQ-008 The block SHALL have output o_nzcv, 4 bits, the combinational flags {N,Z,C,V}, bit 3 = N.
REQ-009 The block SHALL have input i_flags_we, 1 bit, the status-register write enable.
REQ-010 The block SHALL have output o_out_q, N bits, the registered result.
REQ-011 The block SHALL have output o_nzcv_q, 4 bits, the registered flags.
REQ-012 The port declaration order SHALL be i_a, i_b, i_op, o_out, o_nzcv, clk, rst, i_flags_we, o_out_q, o_nzcv_q, keeping existing positional instantiations valid.

Function
REQ-013 i_op 2'b00 SHALL compute ADD, o_out = (i_a + i_b) mod 2^N.
REQ-014 i_op 2'b01 SHALL compute SUB, o_out = i_a + ~i_b + 1 mod 2^N.
REQ-015 i_op 2'b10 SHALL compute AND, o_out = i_a & i_b, bitwise.
REQ-016 i_op 2'b11 SHALL compute OR, o_out = i_a | i_b, bitwise.
REQ-017 N flag SHALL equal o_out[N-1] for all ops.
REQ-018 Z flag SHALL be 1 if and only if o_out == 0, for all ops.
REQ-019 C flag for ADD SHALL be the carry out of bit N-1.
REQ-020 C flag for SUB SHALL be the carry out of i_a + ~i_b + 1, i.e. 1 when there is no borrow (i_a >= i_b unsigned); 0-0 gives C=1.
REQ-021 V flag for ADD SHALL be 1 when i_a and i_b have equal sign bits and o_out's sign bit differs from them.
REQ-022 V flag for SUB SHALL be 1 when i_a and i_b differ in sign and o_out's sign bit differs from i_a's.
REQ-023 For AND and OR, C and V SHALL both be 0.
REQ-024 o_out and o_nzcv SHALL be purely combinational, with zero latency from i_a, i_b and i_op, and independent of clk and rst.
REQ-025 On each rising clk edge with i_flags_we=1, o_out_q SHALL load o_out and o_nzcv_q SHALL load o_nzcv, making the registered outputs valid 1 cycle after the operands.
REQ-026 With i_flags_we=0, o_out_q and o_nzcv_q SHALL hold their values.
REQ-027 X or Z on any input SHALL not be masked; no internal default substitution is made.

Reset
REQ-028 While rst=1, o_out_q SHALL be 0 and o_nzcv_q SHALL be 4'b0000 immediately, without waiting for a clock edge; this takes priority over i_flags_we.
REQ-029 Deasserting rst SHALL leave the registers at 0 until the next enabled clock edge.
REQ-030 rst SHALL NOT affect o_out or o_nzcv.

Structure
REQ-031 A package alu_nzcv_pkg SHALL hold the op encoding enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11) and the flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
REQ-032 A single sub-module alu_nzcv_addsub SHALL implement an N-bit adder with carry-in, returning the sum and the carry out; SUB uses it with ~i_b and carry-in 1.

Verification
REQ-033 ADD test: 0+0 -> out 0, nzcv 0100; 0+FFFFFFFF -> FFFFFFFF, 1000; 1+FFFFFFFF -> 0, 0110; 0000FFFF+1 -> 00010000, 0000; 7FFFFFFF+1 -> 80000000, 1001.
REQ-034 SUB test: 0-0 -> 0, 0110; 00010000-1 -> 0000FFFF, 0010; 0-1 -> FFFFFFFF, 1000; 80000000-1 -> 7FFFFFFF, 0011.
REQ-035 AND/OR test: FFFFFFFF&FFFFFFFF -> FFFFFFFF, 1000; FFFFFFFF&77433477 -> 77433477, 0000; 0&FFFFFFFF -> 0, 0100; 0|FFFFFFFF -> FFFFFFFF, 1000.
REQ-036 Register test: apply 1+FFFFFFFF with i_flags_we=1 -> after the edge, o_nzcv_q=0110; then change the operands with i_flags_we=0 -> o_nzcv_q holds 0110.
REQ-037 Reset test: assert rst between clock edges -> o_out_q=0 and o_nzcv_q=0000 immediately, while o_out and o_nzcv still track the inputs.
REQ-038 Width test: with N=8, 7F+01 -> out 80, nzcv 1001; FF+01 -> 00, 0110.

Source files
------------

// File: rtl/alu_nzcv_pkg.sv
// alu_nzcv_pkg
//   Shared definitions for the NZCV ALU slice: the operation-select encoding
//   carried on i_op and the bit positions of each flag inside the 4-bit
//   {N,Z,C,V} status vector.
package alu_nzcv_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_nzcv_if.sv
// alu_nzcv_if
//   Bundles the ALU operand/result bus so that an environment can carry it as
//   a single object.
//   master : drives a, b, op, flags_we; observes out, nzcv, out_q, nzcv_q
//   slave  : the ALU side of the same bus
interface alu_nzcv_if #(
    parameter int unsigned N = 32
);
    import alu_nzcv_pkg::*;

    logic [N-1:0] a;
    logic [N-1:0] b;
    op_e          op;
    logic         flags_we;
    logic [N-1:0] out;
    logic [3:0]   nzcv;
    logic [N-1:0] out_q;
    logic [3:0]   nzcv_q;

    modport master (
        output a, b, op, flags_we,
        input  out, nzcv, out_q, nzcv_q
    );

    modport slave (
        input  a, b, op, flags_we,
        output out, nzcv, out_q, nzcv_q
    );

endinterface

// File: rtl/alu_nzcv_addsub.sv
// alu_nzcv_addsub
//   N-bit ripple-agnostic adder with carry-in, shared by ADD and SUB.
//   i_a, i_b : addends (N bits)
//   i_cin    : carry into bit 0
//   o_sum    : (i_a + i_b + i_cin) mod 2^N
//   o_cout   : carry out of bit N-1
module alu_nzcv_addsub #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] full;

    always_comb begin
        full   = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
        o_sum  = full[N-1:0];
        o_cout = full[N];
    end

endmodule

// File: rtl/alu_nzcv.sv
// alu_nzcv
//   Two-operand ALU (ADD/SUB/AND/OR) producing a combinational result with
//   NZCV flags, plus an enabled status register capturing both.
//   i_a, i_b    : operands (N bits)
//   i_op        : operation select, see alu_nzcv_pkg::op_e
//   o_out       : combinational result
//   o_nzcv      : combinational flags {N,Z,C,V}
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   i_flags_we  : load o_out/o_nzcv into the registers on the next edge
//   o_out_q     : registered result
//   o_nzcv_q    : registered flags
module alu_nzcv
    import alu_nzcv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_op,
    output logic [N-1:0] o_out,
    output logic [3:0]   o_nzcv,
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flags_we,
    output logic [N-1:0] o_out_q,
    output logic [3:0]   o_nzcv_q
);

    op_e          op;
    logic         is_sub;
    logic [N-1:0] b_eff;
    logic [N-1:0] sum;
    logic         cout;
    logic [N-1:0] res;
    logic         c_flag;
    logic         v_flag;

    logic [N-1:0] out_reg_d, out_reg_q;
    logic [3:0]   nzcv_reg_d, nzcv_reg_q;

    // SUB is A + ~B + 1 through the same adder
    always_comb begin
        op     = op_e'(i_op);
        is_sub = (i_op == OP_SUB);
        b_eff  = is_sub ? ~i_b : i_b;
    end

    alu_nzcv_addsub #(
        .N (N)
    ) u_addsub (
        .i_a    (i_a),
        .i_b    (b_eff),
        .i_cin  (is_sub),
        .o_sum  (sum),
        .o_cout (cout)
    );

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res    = sum;
                c_flag = cout;
                // Overflow on the effective addition A + b_eff: same-signed
                // addends giving a differently-signed sum. For SUB this is
                // exactly "A and B differ in sign, result sign differs from A".
                v_flag = (i_a[N-1] == b_eff[N-1]) && (sum[N-1] != i_a[N-1]);
            end
            OP_AND: res = i_a & i_b;
            OP_OR:  res = i_a | i_b;
            default: begin
                // Unknown select propagates rather than picking an operation
                res    = 'x;
                c_flag = 1'bx;
                v_flag = 1'bx;
            end
        endcase
    end

    always_comb begin
        o_out          = res;
        o_nzcv         = '0;
        o_nzcv[FLAG_N] = res[N-1];
        o_nzcv[FLAG_Z] = (res == '0);
        o_nzcv[FLAG_C] = c_flag;
        o_nzcv[FLAG_V] = v_flag;
    end

    always_comb begin
        out_reg_d  = out_reg_q;
        nzcv_reg_d = nzcv_reg_q;
        if (i_flags_we) begin
            out_reg_d  = o_out;
            nzcv_reg_d = o_nzcv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg_q  <= '0;
            nzcv_reg_q <= '0;
        end else begin
            out_reg_q  <= out_reg_d;
            nzcv_reg_q <= nzcv_reg_d;
        end
    end

    always_comb begin
        o_out_q  = out_reg_q;
        o_nzcv_q = nzcv_reg_q;
    end

endmodule

// File: tb/tb_alu_nzcv.sv
module tb_alu_nzcv;
    import alu_nzcv_pkg::*;

    logic clk;
    logic rst;

    alu_nzcv_if #(.N(32)) bus ();

    alu_nzcv #(.N(32)) dut (
        .i_a        (bus.a),
        .i_b        (bus.b),
        .i_op       (bus.op),
        .o_out      (bus.out),
        .o_nzcv     (bus.nzcv),
        .clk        (clk),
        .rst        (rst),
        .i_flags_we (bus.flags_we),
        .o_out_q    (bus.out_q),
        .o_nzcv_q   (bus.nzcv_q)
    );

    logic [7:0] a8, b8, out8, out8_q;
    logic [1:0] op8;
    logic [3:0] nzcv8, nzcv8_q;
    logic       we8;

    alu_nzcv #(.N(8)) dut8 (
        .i_a        (a8),
        .i_b        (b8),
        .i_op       (op8),
        .o_out      (out8),
        .o_nzcv     (nzcv8),
        .clk        (clk),
        .rst        (rst),
        .i_flags_we (we8),
        .o_out_q    (out8_q),
        .o_nzcv_q   (nzcv8_q)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {nzcv, out} from plain integer arithmetic on 32-bit operands
    function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ua, ub, sa, sb, r, sr;
        logic [31:0] res;
        logic c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                r   = ua + ub;
                sr  = sa + sb;
                res = r[31:0];
                c   = (r >= 64'sd4294967296);
                v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2'b01: begin
                r   = ua - ub;
                sr  = sa - sb;
                res = r[31:0];
                c   = (ua >= ub);
                v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2'b10: res = a & b;
            default: res = a | b;
        endcase
        return {res[31], (res == 32'd0), c, v, res};
    endfunction

    // Expected status register contents
    logic [31:0] exp_out_q;
    logic [3:0]  exp_nzcv_q;
    logic [35:0] cap;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_out_q  <= '0;
            exp_nzcv_q <= '0;
        end else if (bus.flags_we) begin
            cap = model(bus.op, bus.a, bus.b);
            exp_out_q  <= cap[31:0];
            exp_nzcv_q <= cap[35:32];
        end
    end

    // Every-cycle comparison against the model
    logic [35:0] m;
    always @(negedge clk) begin
        m = model(bus.op, bus.a, bus.b);
        chk("cyc_out",    {32'd0, bus.out},    {32'd0, m[31:0]});
        chk("cyc_nzcv",   {60'd0, bus.nzcv},   {60'd0, m[35:32]});
        chk("cyc_out_q",  {32'd0, bus.out_q},  {32'd0, exp_out_q});
        chk("cyc_nzcv_q", {60'd0, bus.nzcv_q}, {60'd0, exp_nzcv_q});
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vecs[13];

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we);
        @(posedge clk);
        #2;
        bus.op       = op_e'(op);
        bus.a        = a;
        bus.b        = b;
        bus.flags_we = we;
    endtask

    initial begin
        vecs[0]  = '{"add_0_0",       2'b00, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100};
        vecs[1]  = '{"add_0_ffff",    2'b00, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000};
        vecs[2]  = '{"add_1_ffff",    2'b00, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0110};
        vecs[3]  = '{"add_ffff_1",    2'b00, 32'h0000FFFF, 32'h00000001, 32'h00010000, 4'b0000};
        vecs[4]  = '{"add_ovf",       2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        vecs[5]  = '{"sub_0_0",       2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0110};
        vecs[6]  = '{"sub_10000_1",   2'b01, 32'h00010000, 32'h00000001, 32'h0000FFFF, 4'b0010};
        vecs[7]  = '{"sub_0_1",       2'b01, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000};
        vecs[8]  = '{"sub_ovf",       2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        vecs[9]  = '{"and_ones",      2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000};
        vecs[10] = '{"and_pattern",   2'b10, 32'hFFFFFFFF, 32'h77433477, 32'h77433477, 4'b0000};
        vecs[11] = '{"and_zero",      2'b10, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0100};
        vecs[12] = '{"or_zero_ones",  2'b11, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000};

        rst          = 1'b1;
        bus.a        = '0;
        bus.b        = '0;
        bus.op       = OP_ADD;
        bus.flags_we = 1'b0;
        a8 = '0; b8 = '0; op8 = 2'b00; we8 = 1'b0;

        #3;
        chk("reset_out_q",  {32'd0, bus.out_q},  64'd0);
        chk("reset_nzcv_q", {60'd0, bus.nzcv_q}, 64'd0);

        @(posedge clk);
        #2 rst = 1'b0;

        // Directed vectors, hand-computed expectations
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            #1;
            chk({vecs[i].name, "_out"},  {32'd0, bus.out},  {32'd0, vecs[i].out});
            chk({vecs[i].name, "_nzcv"}, {60'd0, bus.nzcv}, {60'd0, vecs[i].nzcv});
            m = model(vecs[i].op, vecs[i].a, vecs[i].b);
            chk({vecs[i].name, "_model"}, {28'd0, m}, {28'd0, vecs[i].nzcv, vecs[i].out});
        end

        // Status register load and hold
        drive(2'b00, 32'h00000001, 32'hFFFFFFFF, 1'b1);
        @(posedge clk);
        #1;
        chk("reg_load_nzcv_q", {60'd0, bus.nzcv_q}, {60'd0, 4'b0110});
        chk("reg_load_out_q",  {32'd0, bus.out_q},  64'd0);
        #1;
        bus.flags_we = 1'b0;
        bus.a        = 32'h00000005;
        bus.b        = 32'h00000003;
        @(posedge clk);
        #1;
        chk("reg_hold_nzcv_q", {60'd0, bus.nzcv_q}, {60'd0, 4'b0110});
        chk("reg_hold_out_q",  {32'd0, bus.out_q},  64'd0);

        // Asynchronous reset mid-cycle
        drive(2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_out_q",  {32'd0, bus.out_q},  {32'd0, 32'h80000000});
        chk("pre_rst_nzcv_q", {60'd0, bus.nzcv_q}, {60'd0, 4'b1001});
        #1 rst = 1'b1;
        #1;
        chk("rst_out_q",    {32'd0, bus.out_q},  64'd0);
        chk("rst_nzcv_q",   {60'd0, bus.nzcv_q}, 64'd0);
        chk("rst_out_comb", {32'd0, bus.out},    {32'd0, 32'h80000000});
        chk("rst_nzcv_comb",{60'd0, bus.nzcv},   {60'd0, 4'b1001});
        @(posedge clk);
        #1;
        chk("rst_over_we",  {60'd0, bus.nzcv_q}, 64'd0);
        #1;
        rst          = 1'b0;
        bus.flags_we = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_hold", {32'd0, bus.out_q}, 64'd0);
        #1 bus.flags_we = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_load", {60'd0, bus.nzcv_q}, {60'd0, 4'b1001});

        // Narrow instance
        #1;
        a8 = 8'h7F; b8 = 8'h01; op8 = 2'b00;
        #1;
        chk("n8_ovf_out",  {56'd0, out8},  {56'd0, 8'h80});
        chk("n8_ovf_nzcv", {60'd0, nzcv8}, {60'd0, 4'b1001});
        a8 = 8'hFF;
        #1;
        chk("n8_wrap_out",  {56'd0, out8},  {56'd0, 8'h00});
        chk("n8_wrap_nzcv", {60'd0, nzcv8}, {60'd0, 4'b0110});

        // Mixed vectors for the every-cycle comparison
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: rb = ra;
                2: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            drive(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
